fdl_ctrl: RTL

FDL_CTRL -- requirements
Module: fdl_ctrl

---
 rtl/fdl_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fdl_ctrl.sv
// Fine delay line controller: filters phase-detector votes into a 0..8 delay code,
// drives a registered thermometer bank (T/Tb) and detects lock from step reversals.
module fdl_ctrl #(
    parameter int unsigned INIT_CODE = 4,
    parameter int unsigned FILT_LEN  = 4,
    parameter int unsigned HOLD      = 2,
    parameter int unsigned LOCK_CNT  = 4
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       en,
    input  logic       pd_up,
    input  logic       pd_dn,
    output logic [7:0] T,
    output logic [7:0] Tb,
    output logic [3:0] code,
    output logic       lock,
    output logic       sat_hi,
    output logic       sat_lo
);
    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;

    localparam logic [3:0]        INIT_C   = 4'(INIT_CODE);
    localparam logic signed [4:0] ACC_MAX  = 5'(FILT_LEN);
    localparam logic signed [4:0] ACC_MIN  = -ACC_MAX;
    localparam logic [2:0]        HOLD_C   = 3'(HOLD);
    localparam logic [2:0]        LOCK_C   = 3'(LOCK_CNT);
    localparam logic [3:0]        CODE_MAX = 4'd8;

    function automatic logic [7:0] therm(input logic [3:0] c);
        logic [7:0] t;
        for (int k = 0; k < 8; k++) begin
            t[k] = (k < int'(c));
        end
        return t;
    endfunction

    state_t             state_r, state_s;
    logic [3:0]         code_r, code_s;
    logic signed [3:0]  acc_r, acc_s;
    logic [2:0]         hold_r, hold_s;
    logic [2:0]         rev_r, rev_s;
    logic [1:0]         same_r, same_s;
    logic               dir_r, dir_s;
    logic               dir_vld_r, dir_vld_s;
    logic               lock_r, lock_s;
    logic               sat_hi_r, sat_hi_s;
    logic               sat_lo_r, sat_lo_s;
    logic signed [4:0]  vote_s;
    logic signed [4:0]  sum_s;
    logic               step_up_s;
    logic               at_limit_s;
    logic               same_dir_s;

    // Next-state: vote filtering, code stepping, reversal/lock bookkeeping.
    always_comb begin
        state_s    = state_r;
        code_s     = code_r;
        acc_s      = acc_r;
        hold_s     = hold_r;
        rev_s      = rev_r;
        same_s     = same_r;
        dir_s      = dir_r;
        dir_vld_s  = dir_vld_r;
        lock_s     = lock_r;
        sat_hi_s   = sat_hi_r;
        sat_lo_s   = sat_lo_r;
        step_up_s  = 1'b0;
        at_limit_s = 1'b0;
        same_dir_s = 1'b0;
        if (pd_up && !pd_dn) begin
            vote_s = 5'sd1;
        end else if (pd_dn && !pd_up) begin
            vote_s = -5'sd1;
        end else begin
            vote_s = 5'sd0;
        end
        sum_s = $signed({acc_r[3], acc_r}) + vote_s;

        case (state_r)
            IDLE: begin
                if (en) begin
                    state_s = TRACK;
                    code_s  = INIT_C;
                end else begin
                    state_s = IDLE;
                end
            end
            TRACK, LOCKED: begin
                if (!en) begin
                    state_s   = IDLE;
                    acc_s     = 4'sd0;
                    hold_s    = 3'd0;
                    rev_s     = 3'd0;
                    same_s    = 2'd0;
                    dir_vld_s = 1'b0;
                    lock_s    = 1'b0;
                    sat_hi_s  = 1'b0;
                    sat_lo_s  = 1'b0;
                end else if (hold_r != 3'd0) begin
                    hold_s = hold_r - 3'd1;
                end else if ((sum_s == ACC_MAX) || (sum_s == ACC_MIN)) begin
                    step_up_s  = (sum_s == ACC_MAX);
                    at_limit_s = step_up_s ? (code_r == CODE_MAX) : (code_r == 4'd0);
                    // A pinned step cannot move the line, so it never counts as a reversal.
                    same_dir_s = at_limit_s || (dir_vld_r && (dir_r == step_up_s));
                    acc_s      = 4'sd0;
                    dir_s      = step_up_s;
                    dir_vld_s  = 1'b1;
                    if (at_limit_s) begin
                        if (step_up_s) begin
                            sat_hi_s = 1'b1;
                        end else begin
                            sat_lo_s = 1'b1;
                        end
                    end else begin
                        code_s = step_up_s ? (code_r + 4'd1) : (code_r - 4'd1);
                        hold_s = HOLD_C;
                    end
                    if (same_dir_s) begin
                        rev_s  = 3'd0;
                        same_s = (same_r == 2'd2) ? 2'd2 : (same_r + 2'd1);
                    end else if (dir_vld_r) begin
                        rev_s  = (rev_r >= LOCK_C) ? LOCK_C : (rev_r + 3'd1);
                        same_s = 2'd0;
                    end else begin
                        rev_s  = 3'd0;
                        same_s = same_r;
                    end
                    if ((state_r == TRACK) && (rev_s == LOCK_C)) begin
                        state_s = LOCKED;
                        lock_s  = 1'b1;
                    end else if ((state_r == LOCKED) && (same_s == 2'd2)) begin
                        state_s = TRACK;
                        lock_s  = 1'b0;
                    end else begin
                        state_s = state_r;
                    end
                end else begin
                    acc_s = sum_s[3:0];
                end
            end
            default: begin
                state_s = IDLE;
                lock_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; T and Tb come from the same flop bank.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            code_r    <= INIT_C;
            acc_r     <= 4'sd0;
            hold_r    <= 3'd0;
            rev_r     <= 3'd0;
            same_r    <= 2'd0;
            dir_r     <= 1'b0;
            dir_vld_r <= 1'b0;
            lock_r    <= 1'b0;
            sat_hi_r  <= 1'b0;
            sat_lo_r  <= 1'b0;
            T         <= therm(INIT_C);
            Tb        <= ~therm(INIT_C);
        end else begin
            state_r   <= state_s;
            code_r    <= code_s;
            acc_r     <= acc_s;
            hold_r    <= hold_s;
            rev_r     <= rev_s;
            same_r    <= same_s;
            dir_r     <= dir_s;
            dir_vld_r <= dir_vld_s;
            lock_r    <= lock_s;
            sat_hi_r  <= sat_hi_s;
            sat_lo_r  <= sat_lo_s;
            T         <= therm(code_s);
            Tb        <= ~therm(code_s);
        end
    end

    assign code   = code_r;
    assign lock   = lock_r;
    assign sat_hi = sat_hi_r;
    assign sat_lo = sat_lo_r;
endmodule
